// File: rtl/fft_pkg.sv
// Shared constants, state encoding and address helper for the FFT BRAM loader.
package fft_pkg;

  localparam int unsigned LANES   = 32;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned ROW_LEN = 128;
  localparam int unsigned K_W     = $clog2(ROW_LEN);
  localparam int unsigned J_W     = $clog2(LANES);
  localparam int unsigned I_W     = 2;
  localparam int unsigned CHK_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Word address of element k of row i, wrapping modulo the BRAM depth.
  function automatic logic [ADDR_W-1:0] bram_addr(
    input logic [ADDR_W-1:0] base,
    input logic [I_W-1:0]    row,
    input logic [K_W-1:0]    elem
  );
    return base + ADDR_W'(row) * ADDR_W'(ROW_LEN) + ADDR_W'(elem);
  endfunction

endpackage

// File: rtl/fft_load_counter.sv
// Cascaded element/BRAM/row counter (k innermost, i outermost) for the loader.
module fft_load_counter
  import fft_pkg::*;
#(
  parameter int unsigned ROWS = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [K_W-1:0] k,
  output logic [J_W-1:0] j,
  output logic [I_W-1:0] i,
  output logic           last
);

  logic k_wrap;
  logic j_wrap;

  assign k_wrap = (k == K_W'(ROW_LEN - 1));
  assign j_wrap = (j == J_W'(LANES - 1));
  assign last   = k_wrap && j_wrap && (i == I_W'(ROWS - 1));

  // Step k every accepted sample; carry into j, then into i; restart after the last sample.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k <= '0;
      j <= '0;
      i <= '0;
    end else if (advance) begin
      k <= k + K_W'(1);
      if (k_wrap) begin
        j <= j + J_W'(1);
        if (j_wrap) begin
          i <= last ? '0 : i + I_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fft_bram_loader.sv
// Streams ROWS*4096 samples into 32 FFT BRAMs through registered port-A writes.
// Optional feature: define FFT_LOADER_CHECKSUM_EN to add a running 32-bit checksum output.
module fft_bram_loader
  import fft_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 9'd0,
  parameter int unsigned       ROWS      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic [LANES*ADDR_W-1:0]   FFT_addra,
  output logic [LANES*DATA_W-1:0]   FFT_dataa,
  output logic [LANES-1:0]          FFT_wea,
  output logic                      busy,
  output logic                      done
`ifdef FFT_LOADER_CHECKSUM_EN
  ,
  output logic [CHK_W-1:0]          checksum
`endif
);

  state_t                    state;
  logic                      accept;
  logic                      start_load;
  logic [K_W-1:0]            cnt_k;
  logic [J_W-1:0]            cnt_j;
  logic [I_W-1:0]            cnt_i;
  logic                      cnt_last;
  logic [LANES-1:0]          wea_next;
  logic [LANES*ADDR_W-1:0]   addra_next;
  logic [LANES*DATA_W-1:0]   dataa_next;

  assign accept     = in_valid && in_ready;
  assign start_load = (state == IDLE) && start;

  fft_load_counter #(
    .ROWS(ROWS)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_load),
    .advance(accept),
    .k      (cnt_k),
    .j      (cnt_j),
    .i      (cnt_i),
    .last   (cnt_last)
  );

  // Build the single-lane write word for the current (i, j, k) position.
  always_comb begin
    wea_next   = '0;
    addra_next = '0;
    dataa_next = '0;
    wea_next[cnt_j] = 1'b1;
    addra_next[32'(cnt_j) * ADDR_W +: ADDR_W] = bram_addr(BASE_ADDR, cnt_i, cnt_k);
    dataa_next[32'(cnt_j) * DATA_W +: DATA_W] = in_data;
  end

  // Load sequencer: state, handshake, status and registered BRAM write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      FFT_wea   <= '0;
      FFT_addra <= '0;
      FFT_dataa <= '0;
    end else begin
      done      <= 1'b0;
      FFT_wea   <= '0;
      FFT_addra <= '0;
      FFT_dataa <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            FFT_wea   <= wea_next;
            FFT_addra <= addra_next;
            FFT_dataa <= dataa_next;
            if (cnt_last) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFT_LOADER_CHECKSUM_EN
  // Wrapping sum of sign-extended accepted samples; frozen between done and the next start.
  always_ff @(posedge clk) begin
    if (reset || start_load) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + CHK_W'(signed'(in_data));
    end
  end
`endif

endmodule

// File: tb/tb_fft_bram_loader.sv
// Scoreboard bench for fft_bram_loader: two instances (base 0 and base 256) share stimulus.
`timescale 1ns/1ps
module tb_fft_bram_loader;

  localparam int ROWS  = 2;
  localparam int TOTAL = ROWS * 4096;
  localparam int NL    = 32;

  typedef struct {
    int          lane;
    int          addr;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, in_valid;
  logic [15:0]  in_data;
  logic         rdy0, rdy1, busy0, busy1, done0, done1;
  logic [287:0] addra0, addra1;
  logic [511:0] dataa0, dataa1;
  logic [31:0]  wea0, wea1;
`ifdef FFT_LOADER_CHECKSUM_EN
  logic [31:0]  cks0, cks1;
`endif

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int last_done_edge = -1;

  // Reference model: phase 0 idle, 1 loading, 2 flushing.
  int          m_phase = 0;
  int          m_n = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_sum = '0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] smp[$];
  logic [15:0] img [2][NL][512];
  bit          wr  [2][NL][512];

  fft_bram_loader #(.BASE_ADDR(9'd0), .ROWS(ROWS)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .FFT_addra(addra0), .FFT_dataa(dataa0), .FFT_wea(wea0),
    .busy(busy0), .done(done0)
`ifdef FFT_LOADER_CHECKSUM_EN
    , .checksum(cks0)
`endif
  );

  fft_bram_loader #(.BASE_ADDR(9'd256), .ROWS(ROWS)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .FFT_addra(addra1), .FFT_dataa(dataa1), .FFT_wea(wea1),
    .busy(busy1), .done(done1)
`ifdef FFT_LOADER_CHECKSUM_EN
    , .checksum(cks1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_cnt);
    end
  endtask

  // Expected write for the sample about to be accepted, for both base addresses.
  task automatic push_exp(input logic [15:0] dv);
    exp_t e;
    int   row, elem;
    row    = m_n / 4096;
    elem   = m_n % 128;
    e.lane = (m_n / 128) % 32;
    e.data = dv;
    e.due  = edge_cnt + 1;
    e.addr = (0 + row * 128 + elem) % 512;
    q0.push_back(e);
    e.addr = (256 + row * 128 + elem) % 512;
    q1.push_back(e);
    smp.push_back(dv);
  endtask

  task automatic check_ctrl();
    chk("in_ready0", 32'(rdy0), 32'(m_phase == 1));
    chk("in_ready1", 32'(rdy1), 32'(m_phase == 1));
    chk("busy0", 32'(busy0), 32'(m_phase != 0));
    chk("busy1", 32'(busy1), 32'(m_phase != 0));
    chk("done0", 32'(done0), 32'(m_done));
    chk("done1", 32'(done1), 32'(m_done));
    if (done0 === 1'b1) last_done_edge = edge_cnt;
`ifdef FFT_LOADER_CHECKSUM_EN
    chk("checksum0", cks0, m_sum);
    chk("checksum1", cks1, m_sum);
`endif
  endtask

  // Apply one cycle of inputs at a negedge, advance the model, then check control outputs.
  task automatic drive(input logic r, input logic s, input logic v, input logic [15:0] dv);
    reset = r; start = s; in_valid = v; in_data = dv;
    m_done = 1'b0;
    if (r) begin
      m_phase = 0; m_n = 0; m_sum = '0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_n = 0; m_sum = '0; end
        1: if (v) begin
             push_exp(dv);
             m_sum = m_sum + 32'(signed'(dv));
             m_n++;
             if (m_n == TOTAL) m_phase = 2;
           end
        default: begin m_phase = 0; m_done = 1'b1; end
      endcase
    end
    @(negedge clk);
    check_ctrl();
  endtask

  task automatic check_write(input int d, input bit has, input exp_t e,
                             input logic [31:0] w, input logic [287:0] a, input logic [511:0] dt);
    logic [31:0]  ew;
    logic [287:0] ea;
    logic [511:0] ed;
    checks++;
    if (!has) begin
      errors++;
      $display("FAIL unexpected_write dut%0d: wea %0h with no accepted sample pending (edge %0d)",
               d, w, edge_cnt);
    end else begin
      ew = 32'd1 << e.lane;
      ea = 288'(e.addr) << (9 * e.lane);
      ed = 512'(e.data) << (16 * e.lane);
      if (w !== ew || a !== ea || dt !== ed || e.due != edge_cnt) begin
        errors++;
        $display("FAIL write dut%0d: wea %0h addr %0d data %0h edge %0d, expected wea %0h addr %0d data %0h edge %0d",
                 d, w, a[9*e.lane +: 9], dt[16*e.lane +: 16], edge_cnt, ew, e.addr, e.data, e.due);
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (w[l] === 1'b1) begin
        img[d][l][a[9*l +: 9]] = dt[16*l +: 16];
        wr[d][l][a[9*l +: 9]]  = 1'b1;
      end
    end
  endtask

  // Monitor: every write (or every write that is due but absent) is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    bit   has;
    e = '{lane: 0, addr: 0, data: 16'h0, due: 0};
    if (wea0 != 32'd0 || (q0.size() > 0 && q0[0].due <= edge_cnt)) begin
      has = (q0.size() > 0);
      if (has) e = q0.pop_front();
      check_write(0, has, e, wea0, addra0, dataa0);
    end
    if (wea1 != 32'd0 || (q1.size() > 0 && q1[0].due <= edge_cnt)) begin
      has = (q1.size() > 0);
      if (has) e = q1.pop_front();
      check_write(1, has, e, wea1, addra1, dataa1);
    end
  end

  task automatic clear_image();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < NL; l++)
        for (int a = 0; a < 512; a++) begin
          wr[d][l][a]  = 1'b0;
          img[d][l][a] = 16'h0;
        end
    smp.delete();
  endtask

  // Memory image must hold exactly the loaded samples at (lane j, base + i*128 + k).
  task automatic check_image(input int d);
    int bad, cnt, low, lane, addr, base;
    bad = 0; cnt = 0; low = 0;
    base = (d == 0) ? 0 : 256;
    for (int n = 0; n < smp.size(); n++) begin
      lane = (n / 128) % 32;
      addr = (base + (n / 4096) * 128 + n % 128) % 512;
      if (!wr[d][lane][addr] || img[d][lane][addr] !== smp[n]) bad++;
    end
    for (int l = 0; l < NL; l++)
      for (int a = 0; a < 512; a++)
        if (wr[d][l][a]) begin
          cnt++;
          if (d == 1 && a < 256) low++;
        end
    chk($sformatf("image_bad_dut%0d", d), 32'(bad), 32'd0);
    chk($sformatf("image_words_dut%0d", d), 32'(cnt), 32'(smp.size()));
    if (d == 1) chk("low_half_untouched", 32'(low), 32'd0);
  endtask

  // vmode: 0 continuous, 1 alternating, 2 random; dmode: 0 count, 1 random, 2 all-ones.
  task automatic run_load(input int vmode, input int dmode, input bit mid_start,
                          input int abort_at, output int start_edge);
    int          guard;
    logic        v, s;
    logic [15:0] dv;
    clear_image();
    guard = 0;
    start_edge = edge_cnt;
    drive(1'b0, 1'b1, 1'b0, 16'h0);
    while (m_phase != 0 && guard < 40000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (dmode)
        0:       dv = 16'(m_n) & 16'h7FFF;
        1:       dv = 16'($urandom);
        default: dv = 16'hFFFF;
      endcase
      s = mid_start && (m_n == 3000 || m_n == 5000);
      if (abort_at > 0 && m_n == abort_at) begin
        drive(1'b1, 1'b0, 1'b1, dv);
        return;
      end
      drive(1'b0, s, v, dv);
      guard++;
    end
    chk("load_completes", 32'(m_phase), 32'd0);
  endtask

  initial begin
    int se;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    @(negedge clk);

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    chk("reset_wea0", wea0, 32'd0);
    chk("reset_wea1", wea1, 32'd0);
    chk("reset_addra0_zero", 32'(addra0 != '0), 32'd0);
    chk("reset_dataa0_zero", 32'(dataa0 != '0), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);

    // Continuous count-valued load with done latency check
    run_load(0, 0, 1'b0, 0, se);
    chk("done_latency", 32'(last_done_edge - se), 32'd8194);
    check_image(0);
    check_image(1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0);

    // Alternating in_valid with random data
    run_load(1, 1, 1'b0, 0, se);
    check_image(0);
    check_image(1);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0);

    // Random gaps, reset after 1000 samples while a sample is presented
    run_load(2, 1, 1'b0, 1000, se);
    chk("abort_wea0", wea0, 32'd0);
    chk("abort_wea1", wea1, 32'd0);
    chk("abort_dataa0_zero", 32'(dataa0 != '0), 32'd0);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 16'h0);

    // Reload from scratch with all-ones data and stray start pulses mid-load
    run_load(0, 2, 1'b1, 0, se);
    check_image(0);
    check_image(1);
`ifdef FFT_LOADER_CHECKSUM_EN
    chk("checksum_ffff0", cks0, 32'hFFFF_E000);
    chk("checksum_ffff1", cks1, 32'hFFFF_E000);
`endif
    repeat (5) drive(1'b0, 1'b0, 1'b0, 16'h0);
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bram_loader.md
FFT_BRAM_LOADER -- requirements
Module: fft_bram_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 9'd0; first BRAM word address written.
REQ-002 SHALL have parameter ROWS, default 2; rows loaded per BRAM, range 1..3.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port in_valid  in  1  sample present on in_data.
REQ-007 SHALL have port in_data  in  16  two's-complement sample.
REQ-008 SHALL have port in_ready  out  1  loader accepts the sample this cycle.
REQ-009 SHALL have port FFT_addra  out  288  32 lanes x 9-bit port-A addresses; lane j at bits [9j+8:9j].
REQ-010 SHALL have port FFT_dataa  out  512  32 lanes x 16-bit write data; lane j at bits [16j+15:16j].
REQ-011 SHALL have port FFT_wea  out  32  one-hot port-A write enable, bit j = BRAM j.
REQ-012 SHALL have port busy  out  1  load in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse after the last write.

Function
REQ-014 SHALL implement states IDLE, LOAD, FLUSH: IDLE->LOAD on start; LOAD->FLUSH on the last accepted sample; FLUSH->IDLE after one cycle.
REQ-015 SHALL accept a sample only on a cycle where in_valid && in_ready; in_ready SHALL equal (state==LOAD).
REQ-016 SHALL order samples as row i (outer, 0..ROWS-1), BRAM j (0..31), element k (inner, 0..127); total ROWS*4096 samples.
REQ-017 SHALL write sample (i,j,k) to BRAM j at address BASE_ADDR + i*128 + k, truncated modulo 512.
REQ-018 SHALL register all write outputs, so the write appears exactly one cycle after acceptance.
REQ-019 SHALL drive lane j of FFT_addra and FFT_dataa with the target address and data on a write cycle; all other lanes SHALL be zero.
REQ-020 SHALL drive FFT_wea to zero on every cycle without a write; at most one bit is set.
REQ-021 SHALL tolerate in_valid gaps of any length; the counters SHALL hold while no sample is accepted.
REQ-022 SHALL assert done for one cycle in FLUSH, coincident with FFT_wea==0, and the cycle after the final write.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL assert busy in LOAD and FLUSH.

Reset
REQ-025 SHALL, on reset, enter IDLE and clear the counters.
REQ-026 SHALL, on reset, drive FFT_wea=0, FFT_addra=0, FFT_dataa=0, in_ready=0, busy=0 and done=0 on the following cycle.
REQ-027 SHALL abort a load when reset is asserted during LOAD; a write registered in that cycle SHALL be suppressed.

Configuration
REQ-028 SHALL implement macro FFT_LOADER_CHECKSUM_EN; when defined, add output checksum (out, 32) as the wrapping sum of sign-extended accepted samples.
REQ-029 SHALL clear checksum on reset and on start, and hold it stable from done until the next start.
REQ-030 SHALL, without FFT_LOADER_CHECKSUM_EN, have no checksum port and no accumulator logic.

Structure
REQ-031 SHALL take the lane count 32, lane data width 16, address width 9, row length 128 and the state encoding from the shared package fft_pkg.
REQ-032 SHALL instantiate one sub-module, fft_load_counter: a cascaded k/j/i counter with an advance input and outputs k, j, i and last.

Verification
REQ-033 SHALL cover this scenario: reset, start, then 8192 continuous samples with value n = (count & 16'h7FFF) -> BRAM j addr i*128+k holds its value; done at cycle 8193+1; wea stays one-hot.
REQ-034 SHALL cover this scenario: in_valid toggled on and off each cycle -> same memory image; busy stays high throughout; no write on idle cycles.
REQ-035 SHALL cover this scenario: BASE_ADDR=256, ROWS=2 -> writes land at addresses 256..511 only; addresses 0..255 are untouched.
REQ-036 SHALL cover this scenario: reset asserted after 1000 samples -> next cycle wea=0 and state IDLE; a new start reloads from sample (0,0,0).
REQ-037 SHALL cover this scenario: start pulsed mid-load -> ignored; no counter disturbance.
REQ-038 SHALL cover this scenario: with FFT_LOADER_CHECKSUM_EN, 8192 samples of 16'hFFFF -> checksum 32'hFFFF_E000.
